// File: rtl/bnn_ws_array_pkg.sv
// Shared types and default geometry for the weight-stationary binary array.
package bnn_ws_array_pkg;

  typedef enum logic [1:0] {
    LOAD_W = 2'd0,
    LOAD_A = 2'd1,
    DRAIN  = 2'd2
  } state_e;

  localparam int DEF_WORD       = 27;
  localparam int DEF_ROW_LENGTH = 11;
  localparam int DEF_O_CH       = 6;

endpackage

// File: rtl/bnn_popcount.sv
// XNOR-popcount of one weight word against one activation word.
module bnn_popcount #(
  parameter  int WORD  = 27,
  localparam int CNT_W = $clog2(WORD + 1)
) (
  input  logic [WORD-1:0]  word_a,
  input  logic [WORD-1:0]  word_b,
  output logic [CNT_W-1:0] count
);

  logic [WORD-1:0] match;

  assign match = ~(word_a ^ word_b);

  always_comb begin
    count = '0;
    for (int i = 0; i < WORD; i++) begin
      count = count + CNT_W'(match[i]);
    end
  end

endmodule

// File: rtl/bnn_ws_array.sv
// Weight-stationary binary conv array: weights load once, activations stream,
// one XNOR-popcount accumulator per output channel, results drained per channel.
module bnn_ws_array
  import bnn_ws_array_pkg::*;
#(
  parameter  int WORD       = DEF_WORD,
  parameter  int ROW_LENGTH = DEF_ROW_LENGTH,
  parameter  int O_CH       = DEF_O_CH,
  localparam int N_BITS     = ROW_LENGTH * WORD,
  localparam int PSUM_W     = $clog2(N_BITS + 1),
  localparam int CH_W       = (O_CH > 1) ? $clog2(O_CH) : 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [WORD-1:0]   data_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              reuse_w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PSUM_W-1:0] psum_out,
  output logic              sign_out,
  output logic [CH_W-1:0]   out_ch
);

  localparam int CNT_W = $clog2(WORD + 1);
  localparam int COL_W = (ROW_LENGTH > 1) ? $clog2(ROW_LENGTH) : 1;
  localparam logic [PSUM_W:0] THRESH = (PSUM_W + 1)'(N_BITS);

  state_e            state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [CH_W-1:0]   wch_q, wch_d;
  logic [CH_W-1:0]   och_q, och_d;
  logic [WORD-1:0]   weight_q [O_CH][ROW_LENGTH];
  logic [WORD-1:0]   weight_d [O_CH][ROW_LENGTH];
  logic [PSUM_W-1:0] acc_q [O_CH];
  logic [PSUM_W-1:0] acc_d [O_CH];
  logic [CNT_W-1:0]  match_cnt [O_CH];

  logic accept, last_col, last_wch, last_och;

  assign in_ready = (state_q != DRAIN);
  assign accept   = in_valid & in_ready;
  assign last_col = (col_q == COL_W'(ROW_LENGTH - 1));
  assign last_wch = (wch_q == CH_W'(O_CH - 1));
  assign last_och = (och_q == CH_W'(O_CH - 1));

  // Every channel compares the same activation word against its own weight column.
  for (genvar c = 0; c < O_CH; c++) begin : g_pc
    bnn_popcount #(.WORD(WORD)) u_pc (
      .word_a (data_in),
      .word_b (weight_q[c][col_q]),
      .count  (match_cnt[c])
    );
  end

  always_comb begin
    state_d  = state_q;
    col_d    = col_q;
    wch_d    = wch_q;
    och_d    = och_q;
    weight_d = weight_q;
    acc_d    = acc_q;
    case (state_q)
      LOAD_W: begin
        if (accept) begin
          weight_d[wch_q][col_q] = data_in;
          if (last_col) begin
            col_d = '0;
            if (last_wch) begin
              wch_d   = '0;
              state_d = LOAD_A;
              for (int c = 0; c < O_CH; c++) acc_d[c] = '0;
            end else begin
              wch_d = wch_q + 1'b1;
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      LOAD_A: begin
        if (accept) begin
          for (int c = 0; c < O_CH; c++) acc_d[c] = acc_q[c] + PSUM_W'(match_cnt[c]);
          if (last_col) begin
            col_d   = '0;
            och_d   = '0;
            state_d = DRAIN;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (last_och) begin
            och_d = '0;
            if (reuse_w) begin
              state_d = LOAD_A;
              for (int c = 0; c < O_CH; c++) acc_d[c] = '0;
            end else begin
              state_d = LOAD_W;
            end
          end else begin
            och_d = och_q + 1'b1;
          end
        end
      end
      default: state_d = LOAD_W;
    endcase
  end

  always_comb begin
    out_valid = (state_q == DRAIN);
    psum_out  = out_valid ? acc_q[och_q] : '0;
    out_ch    = out_valid ? och_q : '0;
    sign_out  = out_valid && ({psum_out, 1'b0} >= THRESH);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= LOAD_W;
      col_q   <= '0;
      wch_q   <= '0;
      och_q   <= '0;
      for (int c = 0; c < O_CH; c++) begin
        acc_q[c] <= '0;
        for (int j = 0; j < ROW_LENGTH; j++) weight_q[c][j] <= '0;
      end
    end else begin
      state_q  <= state_d;
      col_q    <= col_d;
      wch_q    <= wch_d;
      och_q    <= och_d;
      acc_q    <= acc_d;
      weight_q <= weight_d;
    end
  end

endmodule

// File: tb/tb_bnn_ws_array.sv
// Directed bench for bnn_ws_array: default geometry plus a small 4x2x2 instance.
module tb_bnn_ws_array;

  localparam int WORD = 27;
  localparam int ROW_LENGTH = 11;
  localparam int O_CH = 6;
  localparam logic [WORD-1:0] ONES = {WORD{1'b1}};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst_n;
  logic [WORD-1:0] data_in;
  logic            in_valid, in_ready, reuse_w, out_valid, out_ready, sign_out;
  logic [8:0]      psum_out;
  logic [2:0]      out_ch;

  logic [3:0] s_data, s_psum;
  logic       s_in_valid, s_in_ready, s_reuse_w, s_out_valid, s_out_ready, s_sign;
  logic [0:0] s_out_ch;

  int errors = 0;
  int checks = 0;

  bnn_ws_array dut (
    .clk_in(clk), .rst_in(rst_n), .data_in(data_in), .in_valid(in_valid),
    .in_ready(in_ready), .reuse_w(reuse_w), .out_valid(out_valid),
    .out_ready(out_ready), .psum_out(psum_out), .sign_out(sign_out), .out_ch(out_ch)
  );

  bnn_ws_array #(.WORD(4), .ROW_LENGTH(2), .O_CH(2)) dut_small (
    .clk_in(clk), .rst_in(rst_n), .data_in(s_data), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .reuse_w(s_reuse_w), .out_valid(s_out_valid),
    .out_ready(s_out_ready), .psum_out(s_psum), .sign_out(s_sign), .out_ch(s_out_ch)
  );

  task automatic push(input logic [WORD-1:0] d);
    int t = 0;
    data_in  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL push_wait: in_ready=%b required 1", in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic s_push(input logic [3:0] d);
    s_data     = d;
    s_in_valid = 1'b1;
    checks++;
    if (s_in_ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL small_push: in_ready=%b required 1", s_in_ready);
    end
    @(posedge clk); #1;
    s_in_valid = 1'b0;
  endtask

  task automatic stall(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    checks += 5;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b required 0", out_valid); end
    if (psum_out !== 9'd0) begin errors++; $display("[TB] FAIL reset_psum: got %0d required 0", psum_out); end
    if (out_ch !== 3'd0) begin errors++; $display("[TB] FAIL reset_out_ch: got %0d required 0", out_ch); end
    if (sign_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_sign: got %b required 0", sign_out); end
  endtask

  task automatic test_all_ones();
    for (int k = 0; k < O_CH * ROW_LENGTH; k++) begin
      push(ONES);
      if (k == 10) stall(3);
    end
    for (int j = 0; j < ROW_LENGTH; j++) begin
      push(ONES);
      if (j == 4) stall(2);
    end
    for (int c = 0; c < O_CH; c++) begin
      checks += 4;
      if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL ones_valid ch%0d: got %b required 1", c, out_valid); end
      if (out_ch !== 3'(c)) begin errors++; $display("[TB] FAIL ones_out_ch: got %0d required %0d", out_ch, c); end
      if (psum_out !== 9'd297) begin errors++; $display("[TB] FAIL ones_psum ch%0d: got %0d required 297", c, psum_out); end
      if (sign_out !== 1'b1) begin errors++; $display("[TB] FAIL ones_sign ch%0d: got %b required 1", c, sign_out); end
      if (c == 2) begin
        out_ready = 1'b0;
        in_valid  = 1'b1;
        data_in   = '0;
        repeat (5) @(posedge clk);
        #1;
        checks += 4;
        if (out_ch !== 3'd2) begin errors++; $display("[TB] FAIL hold_out_ch: got %0d required 2", out_ch); end
        if (psum_out !== 9'd297) begin errors++; $display("[TB] FAIL hold_psum: got %0d required 297", psum_out); end
        if (out_valid !== 1'b1) begin errors++; $display("[TB] FAIL hold_valid: got %b required 1", out_valid); end
        if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL hold_in_ready: got %b required 0", in_ready); end
        in_valid = 1'b0;
      end
      reuse_w   = 1'b1;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL ones_after_in_ready: got %b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL ones_after_valid: got %b required 0", out_valid); end
  endtask

  task automatic test_reuse();
    logic [WORD-1:0] tail [3] = '{27'd0, 27'h0003FFF, 27'h0001FFF};
    int exp_p [3] = '{0, 149, 148};
    logic exp_s [3] = '{1'b0, 1'b1, 1'b0};
    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < ROW_LENGTH; j++)
        push((f != 0 && j < 5) ? ONES : ((j == 5) ? tail[f] : 27'd0));
      for (int c = 0; c < O_CH; c++) begin
        checks += 2;
        if (psum_out !== 9'(exp_p[f])) begin errors++; $display("[TB] FAIL reuse_psum f%0d ch%0d: got %0d required %0d", f, c, psum_out, exp_p[f]); end
        if (sign_out !== exp_s[f]) begin errors++; $display("[TB] FAIL reuse_sign f%0d ch%0d: got %b required %b", f, c, sign_out, exp_s[f]); end
        reuse_w   = (f < 2);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
      end
    end
    checks += 2;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reuse_end_in_ready: got %b required 1", in_ready); end
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reuse_end_valid: got %b required 0", out_valid); end
  endtask

  task automatic test_weight_index();
    for (int c = 0; c < O_CH; c++)
      for (int j = 0; j < ROW_LENGTH; j++)
        push((j <= c) ? ONES : 27'd0);
    for (int j = 0; j < ROW_LENGTH; j++) push(ONES);
    for (int c = 0; c < O_CH; c++) begin
      checks += 2;
      if (psum_out !== 9'(27 * (c + 1))) begin errors++; $display("[TB] FAIL index_psum ch%0d: got %0d required %0d", c, psum_out, 27 * (c + 1)); end
      if (sign_out !== (c == 5)) begin errors++; $display("[TB] FAIL index_sign ch%0d: got %b required %b", c, sign_out, (c == 5)); end
      reuse_w   = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset_mid_drain();
    for (int k = 0; k < O_CH * ROW_LENGTH + ROW_LENGTH; k++) push(ONES);
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    checks++;
    if (out_ch !== 3'd3) begin errors++; $display("[TB] FAIL pre_reset_out_ch: got %0d required 3", out_ch); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    checks += 4;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_valid: got %b required 0", out_valid); end
    if (out_ch !== 3'd0) begin errors++; $display("[TB] FAIL mid_reset_out_ch: got %0d required 0", out_ch); end
    if (psum_out !== 9'd0) begin errors++; $display("[TB] FAIL mid_reset_psum: got %0d required 0", psum_out); end
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL mid_reset_in_ready: got %b required 1", in_ready); end
    for (int k = 0; k < O_CH * ROW_LENGTH + ROW_LENGTH; k++) push(27'd0);
    for (int c = 0; c < O_CH; c++) begin
      checks += 2;
      if (out_ch !== 3'(c)) begin errors++; $display("[TB] FAIL zeros_out_ch: got %0d required %0d", out_ch, c); end
      if (psum_out !== 9'd297) begin errors++; $display("[TB] FAIL zeros_psum ch%0d: got %0d required 297", c, psum_out); end
      reuse_w   = 1'b0;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
    end
  endtask

  task automatic test_small_config();
    logic [3:0] w [4] = '{4'hF, 4'hF, 4'hE, 4'hF};
    int exp_p [2] = '{4, 3};
    logic exp_s [2] = '{1'b1, 1'b0};
    for (int k = 0; k < 4; k++) s_push(w[k]);
    s_push(4'hF);
    s_push(4'h0);
    for (int c = 0; c < 2; c++) begin
      checks += 4;
      if (s_out_valid !== 1'b1) begin errors++; $display("[TB] FAIL small_valid ch%0d: got %b required 1", c, s_out_valid); end
      if (s_out_ch !== 1'(c)) begin errors++; $display("[TB] FAIL small_out_ch: got %0d required %0d", s_out_ch, c); end
      if (s_psum !== 4'(exp_p[c])) begin errors++; $display("[TB] FAIL small_psum ch%0d: got %0d required %0d", c, s_psum, exp_p[c]); end
      if (s_sign !== exp_s[c]) begin errors++; $display("[TB] FAIL small_sign ch%0d: got %b required %b", c, s_sign, exp_s[c]); end
      s_reuse_w   = 1'b0;
      s_out_ready = 1'b1;
      @(posedge clk); #1;
      s_out_ready = 1'b0;
    end
    checks += 2;
    if (s_in_ready !== 1'b1) begin errors++; $display("[TB] FAIL small_end_in_ready: got %b required 1", s_in_ready); end
    if (s_out_valid !== 1'b0) begin errors++; $display("[TB] FAIL small_end_valid: got %b required 0", s_out_valid); end
  endtask

  initial begin
    rst_n       = 1'b0;
    data_in     = '0;
    in_valid    = 1'b0;
    reuse_w     = 1'b0;
    out_ready   = 1'b0;
    s_data      = '0;
    s_in_valid  = 1'b0;
    s_reuse_w   = 1'b0;
    s_out_ready = 1'b0;
    test_reset();
    test_all_ones();
    test_reuse();
    test_weight_index();
    test_reset_mid_drain();
    test_small_config();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bnn_ws_array.md
BNN_WS_ARRAY -- requirements
Module: bnn_ws_array

Interface
REQ-001 SHALL have parameter WORD, default 27: bits per binary word, one 3x3x3 kernel slice.
REQ-002 SHALL have parameter ROW_LENGTH, default 11: words per kernel per output channel.
REQ-003 SHALL have parameter O_CH, default 6: output channels held stationary.
REQ-004 SHALL derive localparam PSUM_W = clog2(ROW_LENGTH*WORD+1) and N_BITS = ROW_LENGTH*WORD.
REQ-005 SHALL have port clk_in, input, 1: single clock, all state on rising edge.
REQ-006 SHALL have port rst_in, input, 1: synchronous active-low reset.
REQ-007 SHALL have port data_in, input, WORD: a weight or activation word.
REQ-008 SHALL have port in_valid, input, 1: data_in is valid.
REQ-009 SHALL have port in_ready, output, 1: the block accepts data_in this cycle.
REQ-010 SHALL have port reuse_w, input, 1: keep the stationary weights for the next frame.
REQ-011 SHALL have port out_valid, output, 1: the result outputs are valid.
REQ-012 SHALL have port out_ready, input, 1: the consumer accepts the result.
REQ-013 SHALL have port psum_out, output, PSUM_W: XNOR-popcount sum for channel out_ch.
REQ-014 SHALL have port sign_out, output, 1: binarised activation, 1 when 2*psum_out >= N_BITS.
REQ-015 SHALL have port out_ch, output, clog2(O_CH): channel index of the current result.

Function
REQ-016 SHALL implement FSM states LOAD_W, LOAD_A and DRAIN; reset enters LOAD_W.
REQ-017 SHALL accept a word only when in_valid and in_ready are both 1; in_ready = 1 in LOAD_W and LOAD_A, 0 in DRAIN.
REQ-018 In LOAD_W, the k-th accepted word (k = 0..O_CH*ROW_LENGTH-1) SHALL be stored as weight[k/ROW_LENGTH][k%ROW_LENGTH].
REQ-019 After the O_CH*ROW_LENGTH-th accepted word, the FSM SHALL go to LOAD_A and the word counter SHALL wrap to 0.
REQ-020 On entry to LOAD_A, all O_CH accumulators SHALL be cleared.
REQ-021 In LOAD_A, accepted activation word j SHALL add popcount(~(data_in ^ weight[c][j])) to acc[c] for every c in the same cycle; the sum is visible one cycle after acceptance.
REQ-022 After activation word ROW_LENGTH-1 is accepted, the FSM SHALL enter DRAIN on the next edge with out_ch = 0.
REQ-023 In DRAIN: out_valid = 1, psum_out = acc[out_ch], sign_out per REQ-014.
REQ-024 Each out_valid & out_ready handshake SHALL advance out_ch by 1; with out_ready low, all outputs SHALL hold.
REQ-025 At the handshake for out_ch = O_CH-1, the FSM SHALL go to LOAD_A if reuse_w = 1 and to LOAD_W otherwise; reuse_w is sampled only at that edge.
REQ-026 Accumulators SHALL be PSUM_W wide and SHALL never overflow; the sign compare SHALL use PSUM_W+1 bits.
REQ-027 In-flight data SHALL be ignored: in_valid while in_ready = 0 is not counted, and stalls (in_valid = 0) in LOAD states SHALL hold all counters.
REQ-028 Outside DRAIN: out_valid = 0, psum_out = 0, sign_out = 0, out_ch = 0.

Reset
REQ-029 While rst_in = 0 at a clock edge, the block SHALL set: state LOAD_W, word counter 0, out_ch 0, all accumulators 0, all weights 0.
REQ-030 Reset asserted mid-load or mid-drain SHALL abort the frame; no partial result SHALL be emitted after release.

Structure
REQ-031 A shared package SHALL hold the state enum and the defaults for WORD, ROW_LENGTH and O_CH.
REQ-032 One sub-module, bnn_popcount (parametrised by WORD), SHALL be instantiated O_CH times.

Verification
REQ-033 Defaults, weights all-ones, activations all-ones -> psum_out = 297 and sign_out = 1 for out_ch 0..5.
REQ-034 Weights all-ones, activations all-zero -> psum_out = 0 and sign_out = 0 on all channels.
REQ-035 WORD = 4, ROW_LENGTH = 2, O_CH = 2, with one channel matching 4 bits and the other 3 -> sign_out = 1 (psum 4) and sign_out = 0 (psum 3).
REQ-036 out_ready low for 5 cycles during out_ch = 2 -> outputs stable, no channel skipped, in_ready held at 0.
REQ-037 reuse_w = 1 at the final handshake, then 11 new activation words -> correct sums without reloading weights; reuse_w = 0 -> in_ready returns in LOAD_W.
REQ-038 rst_in pulsed low in DRAIN at out_ch = 3 -> out_valid = 0 next cycle, state LOAD_W, weights zeroed.
